// File: rtl/sreg_pair_ctrl_pkg.sv
// sreg_pair_ctrl_pkg
//   Shared definitions for the shift-register pair-read controller:
//   FSM state encoding, default widths/capacity, index width, fetch
//   watchdog timeout and the lane ordering used on every 4-lane bus.
package sreg_pair_ctrl_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 32;
  localparam int unsigned DEF_MAX_SIZE   = 19;
  localparam int unsigned IDX_W          = 5;
  localparam int unsigned WD_TIMEOUT     = 64;

  // Lane order on cmd_idx/cmd_mask/sr_idx/res_words: {hr,hl,lr,ll}, hr at MSB.
  localparam int unsigned LANES   = 4;
  localparam int unsigned LANE_LL = 0;
  localparam int unsigned LANE_LR = 1;
  localparam int unsigned LANE_HL = 2;
  localparam int unsigned LANE_HR = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SERVE = 3'd3,
    ST_FETCH = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

endpackage

// File: rtl/sreg_pair_watchdog.sv
// sreg_pair_watchdog
//   Counts consecutive cycles spent waiting for read data. expired_o pulses
//   in the TIMEOUT-th consecutive enabled cycle without a kick.
//   Ports:
//     clk_i      clock
//     rst_n_i    synchronous active-low reset
//     en_i       counting enabled (controller is waiting for read data)
//     kick_i     read data arrived this cycle
//     expired_o  timeout reached this cycle
module sreg_pair_watchdog
  import sreg_pair_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = WD_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic kick_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || kick_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !kick_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sreg_pair_ctrl.sv
// sreg_pair_ctrl
//   Session controller for an external shift register: clears it, loads
//   num_words words from a memory stream, then serves 4-lane fetch commands
//   until a command flagged last has been answered. All outputs registered.
//   Ports:
//     clk, rst_n                         clock, synchronous active-low reset
//     start, num_words                   session request and word count
//     mem_word/mem_valid/mem_ready       source word stream
//     cmd_valid/cmd_ready/cmd_idx/
//     cmd_mask/cmd_last                  fetch commands ({hr,hl,lr,ll})
//     res_valid/res_ready/res_words      fetch results
//     busy, err                          session active, sticky error
//     sr_word_in/sr_word_valid/
//     sr_word_accepted/sr_clear          shift-register load side
//     sr_idx/sr_idx_valid/sr_get_pair/
//     sr_pair_valid/sr_pair_words        shift-register read side
module sreg_pair_ctrl
  import sreg_pair_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned MAX_SIZE   = DEF_MAX_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [IDX_W-1:0]            num_words,
  input  logic [WORD_WIDTH-1:0]       mem_word,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [LANES*IDX_W-1:0]      cmd_idx,
  input  logic [LANES-1:0]            cmd_mask,
  input  logic                        cmd_last,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [LANES*WORD_WIDTH-1:0] res_words,
  output logic                        busy,
  output logic                        err,
  output logic [WORD_WIDTH-1:0]       sr_word_in,
  output logic                        sr_word_valid,
  input  logic                        sr_word_accepted,
  output logic                        sr_clear,
  output logic [LANES*IDX_W-1:0]      sr_idx,
  output logic [LANES-1:0]            sr_idx_valid,
  output logic                        sr_get_pair,
  input  logic                        sr_pair_valid,
  input  logic [LANES*WORD_WIDTH-1:0] sr_pair_words
);

  localparam logic [IDX_W-1:0] MAX_W = IDX_W'(MAX_SIZE);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            num_q, num_d;
  logic [IDX_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            cnt_inc;
  logic                        last_q, last_d;
  logic                        busy_q, busy_d;
  logic                        err_q, err_d;
  logic                        mem_ready_q, mem_ready_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        res_valid_q, res_valid_d;
  logic [LANES*WORD_WIDTH-1:0] res_words_q, res_words_d;
  logic [WORD_WIDTH-1:0]       sr_word_in_q, sr_word_in_d;
  logic                        sr_word_valid_q, sr_word_valid_d;
  logic                        sr_clear_q, sr_clear_d;
  logic [LANES*IDX_W-1:0]      sr_idx_q, sr_idx_d;
  logic [LANES-1:0]            sr_idx_valid_q, sr_idx_valid_d;
  logic                        sr_get_pair_q, sr_get_pair_d;

  logic [LANES-1:0]            lane_ok;
  logic [LANES-1:0]            eff_mask;
  logic                        idx_bad;
  logic [LANES*WORD_WIDTH-1:0] fetch_words;
  logic                        wd_expired;

  sreg_pair_watchdog #(
    .TIMEOUT (WD_TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .en_i      (state_q == ST_FETCH),
    .kick_i    (sr_pair_valid),
    .expired_o (wd_expired)
  );

  // Lane qualification: an enabled lane pointing past the loaded words is
  // dropped from the read and flags an error.
  always_comb begin
    lane_ok     = '0;
    fetch_words = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_ok[l] = cmd_idx[l*IDX_W +: IDX_W] < num_q;
      if (sr_idx_valid_q[l]) begin
        fetch_words[l*WORD_WIDTH +: WORD_WIDTH] = sr_pair_words[l*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    eff_mask = cmd_mask & lane_ok;
    idx_bad  = |(cmd_mask & ~lane_ok);
  end

  assign cnt_inc = cnt_q + IDX_W'(1);

  always_comb begin
    state_d         = state_q;
    num_d           = num_q;
    cnt_d           = cnt_q;
    last_d          = last_q;
    busy_d          = busy_q;
    err_d           = err_q;
    mem_ready_d     = mem_ready_q;
    cmd_ready_d     = cmd_ready_q;
    res_valid_d     = res_valid_q;
    res_words_d     = res_words_q;
    sr_word_in_d    = sr_word_in_q;
    sr_word_valid_d = sr_word_valid_q;
    sr_clear_d      = sr_clear_q;
    sr_idx_d        = sr_idx_q;
    sr_idx_valid_d  = sr_idx_valid_q;
    sr_get_pair_d   = sr_get_pair_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words != '0 && num_words <= MAX_W) begin
            num_d      = num_words;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            sr_clear_d = 1'b1;
            state_d    = ST_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        sr_clear_d  = 1'b0;
        cnt_d       = '0;
        mem_ready_d = 1'b1;
        state_d     = ST_LOAD;
      end

      // mem_ready and sr_word_valid are never high together, so the two
      // handshakes below are mutually exclusive.
      ST_LOAD: begin
        if (mem_ready_q && mem_valid) begin
          sr_word_in_d    = mem_word;
          sr_word_valid_d = 1'b1;
          mem_ready_d     = 1'b0;
        end
        if (sr_word_valid_q && sr_word_accepted) begin
          sr_word_valid_d = 1'b0;
          cnt_d           = cnt_inc;
          if (cnt_inc == num_q) begin
            cmd_ready_d = 1'b1;
            state_d     = ST_SERVE;
          end else begin
            mem_ready_d = 1'b1;
          end
        end
      end

      ST_SERVE: begin
        if (cmd_valid && cmd_ready_q) begin
          sr_idx_d       = cmd_idx;
          sr_idx_valid_d = eff_mask;
          last_d         = cmd_last;
          err_d          = err_q | idx_bad;
          sr_get_pair_d  = 1'b1;
          cmd_ready_d    = 1'b0;
          state_d        = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (sr_pair_valid) begin
          res_words_d    = fetch_words;
          res_valid_d    = 1'b1;
          sr_get_pair_d  = 1'b0;
          sr_idx_valid_d = '0;
          state_d        = ST_RESP;
        end else if (wd_expired) begin
          res_words_d    = '0;
          res_valid_d    = 1'b1;
          err_d          = 1'b1;
          sr_get_pair_d  = 1'b0;
          sr_idx_valid_d = '0;
          state_d        = ST_RESP;
        end
      end

      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (last_q) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cmd_ready_d = 1'b1;
            state_d     = ST_SERVE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      num_q           <= '0;
      cnt_q           <= '0;
      last_q          <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      mem_ready_q     <= 1'b0;
      cmd_ready_q     <= 1'b0;
      res_valid_q     <= 1'b0;
      res_words_q     <= '0;
      sr_word_in_q    <= '0;
      sr_word_valid_q <= 1'b0;
      sr_clear_q      <= 1'b0;
      sr_idx_q        <= '0;
      sr_idx_valid_q  <= '0;
      sr_get_pair_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      num_q           <= num_d;
      cnt_q           <= cnt_d;
      last_q          <= last_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      mem_ready_q     <= mem_ready_d;
      cmd_ready_q     <= cmd_ready_d;
      res_valid_q     <= res_valid_d;
      res_words_q     <= res_words_d;
      sr_word_in_q    <= sr_word_in_d;
      sr_word_valid_q <= sr_word_valid_d;
      sr_clear_q      <= sr_clear_d;
      sr_idx_q        <= sr_idx_d;
      sr_idx_valid_q  <= sr_idx_valid_d;
      sr_get_pair_q   <= sr_get_pair_d;
    end
  end

  assign mem_ready     = mem_ready_q;
  assign cmd_ready     = cmd_ready_q;
  assign res_valid     = res_valid_q;
  assign res_words     = res_words_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign sr_word_in    = sr_word_in_q;
  assign sr_word_valid = sr_word_valid_q;
  assign sr_clear      = sr_clear_q;
  assign sr_idx        = sr_idx_q;
  assign sr_idx_valid  = sr_idx_valid_q;
  assign sr_get_pair   = sr_get_pair_q;

endmodule

// File: tb/tb_sreg_pair_ctrl.sv
// tb_sreg_pair_ctrl
//   Directed bench for sreg_pair_ctrl. The bench plays both the memory
//   source and the shift register; word contents come from wd(session, i).
module tb_sreg_pair_ctrl;
  import sreg_pair_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [4:0]   num_words;
  logic [31:0]  mem_word;
  logic         mem_valid;
  logic         mem_ready;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [19:0]  cmd_idx;
  logic [3:0]   cmd_mask;
  logic         cmd_last;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_words;
  logic         busy;
  logic         err;
  logic [31:0]  sr_word_in;
  logic         sr_word_valid;
  logic         sr_word_accepted;
  logic         sr_clear;
  logic [19:0]  sr_idx;
  logic [3:0]   sr_idx_valid;
  logic         sr_get_pair;
  logic         sr_pair_valid;
  logic [127:0] sr_pair_words;

  int nerr = 0;
  int nchk = 0;
  int clr_cnt = 0;
  int pushes = 0;

  always #5 clk = ~clk;

  sreg_pair_ctrl #(
    .WORD_WIDTH (32),
    .MAX_SIZE   (19)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .num_words        (num_words),
    .mem_word         (mem_word),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_idx          (cmd_idx),
    .cmd_mask         (cmd_mask),
    .cmd_last         (cmd_last),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_words        (res_words),
    .busy             (busy),
    .err              (err),
    .sr_word_in       (sr_word_in),
    .sr_word_valid    (sr_word_valid),
    .sr_word_accepted (sr_word_accepted),
    .sr_clear         (sr_clear),
    .sr_idx           (sr_idx),
    .sr_idx_valid     (sr_idx_valid),
    .sr_get_pair      (sr_get_pair),
    .sr_pair_valid    (sr_pair_valid),
    .sr_pair_words    (sr_pair_words)
  );

  function automatic logic [31:0] wd(input int b, input int i);
    return 32'h5A00_0007 + 32'(b) * 32'h0001_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic logic [19:0] mk_idx(input int hr, input int hl, input int lr, input int ll);
    return {5'(hr), 5'(hl), 5'(lr), 5'(ll)};
  endfunction

  function automatic logic [3:0] mk_mask(input bit hr, input bit hl, input bit lr, input bit ll);
    logic [3:0] m;
    m = '0;
    m[LANE_HR] = hr;
    m[LANE_HL] = hl;
    m[LANE_LR] = lr;
    m[LANE_LL] = ll;
    return m;
  endfunction

  function automatic logic [127:0] quad(input logic [31:0] hr, input logic [31:0] hl,
                                        input logic [31:0] lr, input logic [31:0] ll);
    return {hr, hl, lr, ll};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (sr_clear === 1'b1) clr_cnt++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 128'({busy, err, mem_ready, cmd_ready, res_valid, sr_clear,
                               sr_word_valid, sr_get_pair, sr_idx_valid}), 128'(0));
    chk({tag, "_buses"}, 128'({sr_idx, sr_word_in}), 128'(0));
    chk({tag, "_res"}, res_words, 128'(0));
  endtask

  task automatic load_words(input int n, input int b);
    for (int i = 0; i < n; i++) begin
      chk("load_mem_ready", 128'(mem_ready), 128'(1));
      mem_valid = 1'b1;
      mem_word  = wd(b, i);
      tick();
      mem_valid = 1'b0;
      mem_word  = '0;
      chk("push_word", 128'({sr_word_valid, sr_word_in}), 128'({1'b1, wd(b, i)}));
      if (i == 0) begin
        tick();
        tick();
        chk("push_hold", 128'({sr_word_valid, mem_ready, sr_word_in}), 128'({1'b1, 1'b0, wd(b, 0)}));
      end
      if (sr_word_valid === 1'b1) pushes++;
      sr_word_accepted = 1'b1;
      tick();
      sr_word_accepted = 1'b0;
      chk("push_done", 128'(sr_word_valid), 128'(0));
    end
  endtask

  task automatic send_cmd(input logic [19:0] idx, input logic [3:0] mask, input logic last,
                          input logic [3:0] exp_valid);
    chk("cmd_ready", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1;
    cmd_idx   = idx;
    cmd_mask  = mask;
    cmd_last  = last;
    tick();
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    chk("cmd_accept", 128'({sr_get_pair, cmd_ready, sr_idx_valid, sr_idx}),
        128'({1'b1, 1'b0, exp_valid, idx}));
  endtask

  task automatic respond(input logic [127:0] pair, input logic [127:0] exp);
    sr_pair_valid = 1'b1;
    sr_pair_words = pair;
    tick();
    sr_pair_valid = 1'b0;
    sr_pair_words = '0;
    chk("resp_flags", 128'({res_valid, sr_get_pair}), 128'(2'b10));
    chk("res_words", res_words, exp);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("consume", 128'(res_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] exp_q;
    rst_n = 1'b0; start = 1'b0; num_words = '0; mem_word = '0; mem_valid = 1'b0;
    cmd_valid = 1'b0; cmd_idx = '0; cmd_mask = '0; cmd_last = 1'b0; res_ready = 1'b0;
    sr_word_accepted = 1'b0; sr_pair_valid = 1'b0; sr_pair_words = '0;

    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Illegal session sizes
    start = 1'b1; num_words = 5'd0;
    tick();
    start = 1'b0;
    chk("start_n0", 128'({err, busy, sr_clear}), 128'(3'b100));
    start = 1'b1; num_words = 5'd20;
    tick();
    start = 1'b0;
    chk("start_n20", 128'({err, busy, sr_clear}), 128'(3'b100));

    // Session 1: 19 words
    clr_cnt = 0;
    pushes  = 0;
    start = 1'b1; num_words = 5'd19;
    tick();
    start = 1'b0; num_words = '0;
    chk("start_legal", 128'({busy, err, sr_clear}), 128'(3'b101));
    tick();
    chk("clear_done", 128'({sr_clear, mem_ready}), 128'(2'b01));
    load_words(19, 1);
    chk("serve_entry", 128'({cmd_ready, mem_ready}), 128'(2'b10));
    chk("push_count", 128'(pushes), 128'(19));
    chk("clear_pulses", 128'(clr_cnt), 128'(1));

    start = 1'b1; num_words = 5'd0;
    tick();
    start = 1'b0;
    chk("start_ignored", 128'({err, busy, cmd_ready}), 128'(3'b011));

    // Full-mask read
    send_cmd(mk_idx(16, 17, 14, 15), 4'b1111, 1'b0, 4'b1111);
    tick();
    chk("fetch_hold", 128'({sr_get_pair, res_valid, sr_idx}), 128'({1'b1, 1'b0, mk_idx(16, 17, 14, 15)}));
    respond(quad(wd(1, 16), wd(1, 17), wd(1, 14), wd(1, 15)),
            quad(wd(1, 16), wd(1, 17), wd(1, 14), wd(1, 15)));
    chk("err_clean", 128'(err), 128'(0));
    consume();

    // Partial mask: hl and ll disabled
    send_cmd(mk_idx(16, 17, 14, 15), mk_mask(1, 0, 1, 0), 1'b0, 4'b1010);
    respond(quad(wd(1, 16), wd(1, 17), wd(1, 14), wd(1, 15)),
            quad(wd(1, 16), 32'h0, wd(1, 14), 32'h0));
    consume();

    // Out-of-range index on hr lane
    send_cmd(mk_idx(20, 17, 14, 15), 4'b1111, 1'b0, 4'b0111);
    chk("err_idx", 128'(err), 128'(1));
    respond(quad(wd(1, 20), wd(1, 17), wd(1, 14), wd(1, 15)),
            quad(32'h0, wd(1, 17), wd(1, 14), wd(1, 15)));
    consume();

    // Last command with back-pressured result
    send_cmd(mk_idx(5, 6, 7, 8), 4'b1111, 1'b1, 4'b1111);
    exp_q = quad(wd(1, 5), wd(1, 6), wd(1, 7), wd(1, 8));
    respond(exp_q, exp_q);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("res_stable_v", 128'(res_valid), 128'(1));
      chk("res_stable_w", res_words, exp_q);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("session1_end", 128'({busy, res_valid, cmd_ready, err}), 128'(4'b0001));

    // Session 2: watchdog expiry
    start = 1'b1; num_words = 5'd3;
    tick();
    start = 1'b0; num_words = '0;
    chk("start2_err_clr", 128'({busy, err}), 128'(2'b10));
    tick();
    load_words(3, 2);
    send_cmd(mk_idx(0, 1, 2, 0), 4'b1111, 1'b1, 4'b1111);
    for (int k = 0; k < 63; k++) tick();
    chk("wd_waiting", 128'({sr_get_pair, res_valid, err}), 128'(3'b100));
    tick();
    chk("wd_expired", 128'({res_valid, err, sr_get_pair}), 128'(3'b110));
    chk("wd_res_zero", res_words, 128'(0));
    consume();
    chk("session2_end", 128'({busy, err}), 128'(2'b01));

    // Session 3: reset in the middle of loading
    start = 1'b1; num_words = 5'd5;
    tick();
    start = 1'b0; num_words = '0;
    tick();
    mem_valid = 1'b1; mem_word = wd(3, 0);
    tick();
    mem_valid = 1'b0; mem_word = '0;
    chk("mid_load_push", 128'({busy, sr_word_valid}), 128'(2'b11));
    rst_n = 1'b0;
    tick();
    chk_zero("rst_mid");
    rst_n = 1'b1;
    tick();
    chk_zero("post_rst");

    // Reset clears a sticky error
    start = 1'b1; num_words = 5'd0;
    tick();
    start = 1'b0;
    chk("err_again", 128'(err), 128'(1));
    rst_n = 1'b0;
    tick();
    chk("rst_err", 128'(err), 128'(0));
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
